// File: rtl/fas_pkg.sv
// Shared constants and types for the FAS spectrum peak detector.
// The bin layout is {re[31:16], im[15:0]}, both signed two's complement.
package fas_pkg;

  localparam int NUM_BINS  = 16;
  localparam int BIN_IDX_W = 4;
  localparam int DW        = 16;
  localparam int MW        = 2 * DW;

  localparam int RE_MSB = 31;
  localparam int RE_LSB = 16;
  localparam int IM_MSB = 15;
  localparam int IM_LSB = 0;

  typedef logic [2*DW-1:0]      bin_t;
  typedef logic [MW-1:0]        mag_t;
  typedef logic [BIN_IDX_W-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    REPORT
  } state_t;

endpackage

// File: rtl/fas_mag_sq.sv
// Combinational squared magnitude of one packed complex bin.
// Each square is non-negative and at most 2^30, so the unsigned sum fits in MW bits.
module fas_mag_sq
  import fas_pkg::*;
(
  input  bin_t bin,
  output mag_t mag
);

  logic signed [DW-1:0] re;
  logic signed [DW-1:0] im;
  logic signed [MW-1:0] re_x;
  logic signed [MW-1:0] im_x;
  logic signed [MW-1:0] re_sq;
  logic signed [MW-1:0] im_sq;

  assign re = bin[RE_MSB:RE_LSB];
  assign im = bin[IM_MSB:IM_LSB];

  assign re_x = {{(MW-DW){re[DW-1]}}, re};
  assign im_x = {{(MW-DW){im[DW-1]}}, im};

  assign re_sq = re_x * re_x;
  assign im_sq = im_x * im_x;

  assign mag = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fas_peak_detector.sv
// Captures a 16-bin FFT frame, scans one bin per cycle for the strongest
// squared magnitude and reports its index with a one-cycle done pulse.
module fas_peak_detector
  import fas_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  output logic        done,
  output logic [3:0]  freq
);

  bin_t   frame_in [NUM_BINS];
  bin_t   work     [NUM_BINS];
  bin_t   pend     [NUM_BINS];

  state_t state;
  idx_t   idx;
  idx_t   best;
  mag_t   max_mag;
  mag_t   mag;
  logic   pend_full;

  logic   start_new;
  logic   drain_pend;
  logic   load_pend;

  assign frame_in[0]  = fft_d0;
  assign frame_in[1]  = fft_d1;
  assign frame_in[2]  = fft_d2;
  assign frame_in[3]  = fft_d3;
  assign frame_in[4]  = fft_d4;
  assign frame_in[5]  = fft_d5;
  assign frame_in[6]  = fft_d6;
  assign frame_in[7]  = fft_d7;
  assign frame_in[8]  = fft_d8;
  assign frame_in[9]  = fft_d9;
  assign frame_in[10] = fft_d10;
  assign frame_in[11] = fft_d11;
  assign frame_in[12] = fft_d12;
  assign frame_in[13] = fft_d13;
  assign frame_in[14] = fft_d14;
  assign frame_in[15] = fft_d15;

  // A frame arriving in REPORT with nothing pending goes straight into work,
  // so it is neither stranded in pend nor delayed behind an IDLE cycle.
  always_comb begin
    start_new  = 1'b0;
    drain_pend = 1'b0;
    load_pend  = 1'b0;
    start_new  = fft_valid && ((state == IDLE) || ((state == REPORT) && !pend_full));
    drain_pend = (state == REPORT) && pend_full;
    load_pend  = fft_valid && !start_new && (state != IDLE);
  end

  fas_mag_sq u_mag_sq (
    .bin (work[idx]),
    .mag (mag)
  );

  // Frame storage carries data only, so it has no reset.
  always_ff @(posedge clk) begin
    if (start_new) begin
      work <= frame_in;
    end else if (drain_pend) begin
      work <= pend;
    end
    if (load_pend) begin
      pend <= frame_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      best      <= '0;
      max_mag   <= '0;
      pend_full <= 1'b0;
      done      <= 1'b0;
      freq      <= '0;
    end else begin
      done <= 1'b0;

      if (load_pend) begin
        pend_full <= 1'b1;
      end else if (drain_pend) begin
        pend_full <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start_new) begin
            state   <= SCAN;
            idx     <= '0;
            best    <= '0;
            max_mag <= '0;
          end
        end

        SCAN: begin
          // Strict compare keeps the lowest index on ties.
          if (mag > max_mag) begin
            max_mag <= mag;
            best    <= idx;
          end
          idx <= idx + 1'b1;
          if (idx == idx_t'(NUM_BINS - 1)) begin
            state <= REPORT;
          end
        end

        REPORT: begin
          done <= 1'b1;
          freq <= best;
          if (drain_pend || start_new) begin
            state   <= SCAN;
            idx     <= '0;
            best    <= '0;
            max_mag <= '0;
          end else begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fas_peak_detector.sv
// Scoreboard bench for fas_peak_detector: directed frames from the test plan
// followed by randomized frames at random spacing, checked against a frame-level model.
module tb_fas_peak_detector;

  typedef logic [31:0] frame_t [16];

  typedef struct {
    int freq;
    int at_cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        fft_valid;
  logic [31:0] d [16];
  logic        done;
  logic [3:0]  freq;

  int     n_checks;
  int     n_fail;
  int     cyc;
  int     mon_freq;
  exp_t   sb [$];
  frame_t fr;

  int m_busy;
  int m_end;
  int m_cur;
  int m_pend_v;
  int m_pend;

  fas_peak_detector dut (
    .clk       (clk),
    .rst       (rst),
    .fft_valid (fft_valid),
    .fft_d0    (d[0]),
    .fft_d1    (d[1]),
    .fft_d2    (d[2]),
    .fft_d3    (d[3]),
    .fft_d4    (d[4]),
    .fft_d5    (d[5]),
    .fft_d6    (d[6]),
    .fft_d7    (d[7]),
    .fft_d8    (d[8]),
    .fft_d9    (d[9]),
    .fft_d10   (d[10]),
    .fft_d11   (d[11]),
    .fft_d12   (d[12]),
    .fft_d13   (d[13]),
    .fft_d14   (d[14]),
    .fft_d15   (d[15]),
    .done      (done),
    .freq      (freq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string nm, input longint act, input longint req);
    n_checks = n_checks + 1;
    if (act != req) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input int re, input int im);
    logic [31:0] r;
    r = {re[15:0], im[15:0]};
    return r;
  endfunction

  // Peak = lowest index among the bins holding the largest power.
  function automatic int peak(input frame_t f);
    longint m [16];
    longint mx;
    longint r;
    longint i;
    int     found;
    mx = 0;
    for (int k = 0; k < 16; k++) begin
      r = longint'($signed(f[k][31:16]));
      i = longint'($signed(f[k][15:0]));
      m[k] = r * r + i * i;
      if (m[k] > mx) mx = m[k];
    end
    found = -1;
    for (int k = 0; k < 16; k++) begin
      if (found < 0 && m[k] == mx) found = k;
    end
    return found;
  endfunction

  // Frame-level timing model: a frame captured at edge e reports at edge e+17;
  // frames arriving while busy replace any older pending frame.
  task automatic model_step(input logic v, input int pk);
    int e;
    exp_t x;
    e = cyc + 1;
    if (m_busy != 0 && e == m_end) begin
      x.freq   = m_cur;
      x.at_cyc = e;
      sb.push_back(x);
      if (m_pend_v != 0) begin
        m_cur    = m_pend;
        m_end    = e + 17;
        m_pend_v = 0;
        if (v) begin
          m_pend_v = 1;
          m_pend   = pk;
        end
      end else if (v) begin
        m_cur = pk;
        m_end = e + 17;
      end else begin
        m_busy = 0;
      end
    end else if (m_busy != 0) begin
      if (v) begin
        m_pend_v = 1;
        m_pend   = pk;
      end
    end else if (v) begin
      m_busy = 1;
      m_cur  = pk;
      m_end  = e + 17;
    end
  endtask

  task automatic model_reset();
    m_busy   = 0;
    m_pend_v = 0;
    m_end    = 0;
    m_cur    = 0;
    m_pend   = 0;
    sb.delete();
    mon_freq = 0;
  endtask

  task automatic cycle(input logic v);
    @(negedge clk);
    fft_valid = v;
    for (int k = 0; k < 16; k++) d[k] = v ? fr[k] : $urandom();
    model_step(v, peak(fr));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cycle(1'b0);
  endtask

  task automatic clear_fr();
    for (int k = 0; k < 16; k++) fr[k] = '0;
  endtask

  task automatic rand_fr();
    int mode;
    int re;
    int im;
    int ext [4];
    ext[0] = -32768;
    ext[1] = 32767;
    ext[2] = 0;
    ext[3] = -1;
    mode = int'($urandom_range(0, 2));
    for (int k = 0; k < 16; k++) begin
      case (mode)
        0: begin
          re = int'($urandom_range(0, 6)) - 3;
          im = int'($urandom_range(0, 6)) - 3;
        end
        1: begin
          re = int'($urandom);
          im = int'($urandom);
        end
        default: begin
          re = ext[$urandom_range(0, 3)];
          im = ext[$urandom_range(0, 3)];
        end
      endcase
      fr[k] = mk(re, im);
    end
  endtask

  // Monitor: pops the scoreboard on every done and otherwise checks that freq holds.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (done) begin
          if (sb.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            x = sb.pop_front();
            check("done_freq", longint'(freq), longint'(x.freq));
            check("done_cycle", longint'(cyc), longint'(x.at_cyc));
            mon_freq = x.freq;
          end
        end else begin
          check("freq_hold", longint'(freq), longint'(mon_freq));
        end
      end
    end
  end

  initial begin
    #2000000;
    n_fail = n_fail + 1;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b0;
    fft_valid = 1'b0;
    for (int k = 0; k < 16; k++) d[k] = '0;
    model_reset();
    clear_fr();

    repeat (3) @(negedge clk);
    check("reset_done", longint'(done), 0);
    check("reset_freq", longint'(freq), 0);
    rst = 1'b1;
    idle(3);

    // Single peak at bin 5
    clear_fr();
    fr[5] = mk(100, 0);
    cycle(1'b1);
    idle(25);

    // Tie between bins 3 and 9
    clear_fr();
    fr[3] = mk(30, 40);
    fr[9] = mk(-50, 0);
    cycle(1'b1);
    idle(25);

    // Full-scale extremes
    clear_fr();
    fr[2]  = mk(32767, 0);
    fr[12] = mk(-32768, -32768);
    cycle(1'b1);
    idle(25);

    // All-zero frame
    clear_fr();
    cycle(1'b1);
    idle(25);

    // Overlap: A, B after 5 cycles, C after 8 cycles; B is dropped
    clear_fr();
    fr[7] = mk(500, -500);
    cycle(1'b1);
    idle(4);
    clear_fr();
    fr[1] = mk(900, 900);
    cycle(1'b1);
    idle(2);
    clear_fr();
    fr[14] = mk(-700, 20);
    cycle(1'b1);
    idle(45);

    // Hold after a report of 11
    clear_fr();
    fr[11] = mk(3, -4);
    cycle(1'b1);
    idle(17 + 50);

    // Reset in the middle of a scan
    clear_fr();
    fr[9] = mk(1000, 1000);
    cycle(1'b1);
    idle(7);
    @(negedge clk);
    #2;
    rst       = 1'b0;
    fft_valid = 1'b0;
    model_reset();
    #1;
    check("midscan_reset_done", longint'(done), 0);
    check("midscan_reset_freq", longint'(freq), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    idle(30);

    // Next frame after the abandoned one
    clear_fr();
    fr[6] = mk(-20, 20);
    cycle(1'b1);
    idle(25);

    // Randomized frames at random spacing, including back-to-back strobes
    for (int n = 0; n < 150; n++) begin
      rand_fr();
      cycle(1'b1);
      idle(int'($urandom_range(0, 24)));
    end

    fft_valid = 1'b0;
    for (int w = 0; w < 100 && sb.size() != 0; w++) @(negedge clk);
    repeat (5) @(negedge clk);
    check("scoreboard_drained", longint'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
